// File: rtl/csi2_lane_delay_cal.sv
// csi2_lane_delay_cal: per-lane IDELAY tap sweep for the CSI2 receive path.
// Each lane is swept through taps 0..31. A tap is scored bad if any header/CRC
// error pulse is seen while frames are observed, or if frames stop arriving.
// The lane is then parked at the centre of its widest error-free run of taps.
module csi2_lane_delay_cal #(
    parameter int DATA_LANES     = 2,
    parameter int INIT_TAP       = 16,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int WINDOW_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 2**22
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         frame_start_i,
    input  logic                         header_err_i,
    input  logic                         corr_header_err_i,
    input  logic                         crc_err_i,
    output logic                         delay_act_o,
    output logic [DATA_LANES-1:0][4:0]   lane_delay_o,
    output logic [DATA_LANES-1:0][5:0]   eye_width_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         fail_o
);

    // One counter serves both the settle wait and the frame timeout.
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int LW      = (DATA_LANES > 1) ? $clog2(DATA_LANES) : 1;
    localparam int FW      = $clog2(WINDOW_FRAMES + 1);

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] WIN_LAST     = FW'(WINDOW_FRAMES - 1);
    localparam logic [LW-1:0] LANE_LAST    = LW'(DATA_LANES - 1);
    localparam logic [4:0]    INIT5        = 5'(INIT_TAP);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_LOAD, S_SETTLE, S_SYNC, S_OBSERVE, S_EVAL, S_APPLY, S_DONE
    } state_t;

    state_t          state;
    logic [4:0]      tap;
    logic [LW-1:0]   lane;
    logic [CW-1:0]   cnt;
    logic [FW-1:0]   frames;
    logic            bad;
    logic [5:0]      run_len;
    logic [4:0]      run_start;
    logic [5:0]      best_len;
    logic [4:0]      best_start;
    logic            fail_acc;

    logic            err_any;
    logic [5:0]      run_next;
    logic [4:0]      centre;

    // A corrected header error still means the sampling point is marginal.
    assign err_any  = header_err_i | corr_header_err_i | crc_err_i;
    assign run_next = run_len + 6'd1;
    // best_start + best_len <= 32, so the centre always fits in 5 bits.
    assign centre   = best_start + best_len[5:1];

    // Calibration sequencer; all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_INIT;
            tap          <= '0;
            lane         <= '0;
            cnt          <= '0;
            frames       <= '0;
            bad          <= 1'b0;
            run_len      <= '0;
            run_start    <= '0;
            best_len     <= '0;
            best_start   <= '0;
            fail_acc     <= 1'b0;
            delay_act_o  <= 1'b0;
            lane_delay_o <= {DATA_LANES{INIT5}};
            eye_width_o  <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            fail_o       <= 1'b0;
        end else begin
            delay_act_o <= 1'b0;
            case (state)
                S_INIT: begin
                    delay_act_o <= 1'b1;
                    state       <= S_IDLE;
                end
                S_IDLE: begin
                    if (start_i) begin
                        lane         <= '0;
                        tap          <= '0;
                        done_o       <= 1'b0;
                        fail_o       <= 1'b0;
                        fail_acc     <= 1'b0;
                        eye_width_o  <= '0;
                        run_len      <= '0;
                        run_start    <= '0;
                        best_len     <= '0;
                        best_start   <= '0;
                        lane_delay_o <= {DATA_LANES{INIT5}};
                        busy_o       <= 1'b1;
                        state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    lane_delay_o[lane] <= tap;
                    delay_act_o        <= 1'b1;
                    cnt                <= '0;
                    bad                <= 1'b0;
                    state              <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= S_SYNC;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_SYNC: begin
                    // Errors here belong to a partial frame and are ignored.
                    if (frame_start_i) begin
                        cnt    <= '0;
                        frames <= '0;
                        state  <= S_OBSERVE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        bad   <= 1'b1;
                        state <= S_EVAL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_OBSERVE: begin
                    if (err_any) bad <= 1'b1;
                    if (frame_start_i) begin
                        cnt <= '0;
                        if (frames == WIN_LAST) state <= S_EVAL;
                        else                    frames <= frames + FW'(1);
                    end else if (cnt == TIMEOUT_LAST) begin
                        bad   <= 1'b1;
                        state <= S_EVAL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_EVAL: begin
                    if (!bad) begin
                        if (run_len == 6'd0) run_start <= tap;
                        run_len <= run_next;
                        // Strictly greater: on a tie the earlier run wins.
                        if (run_next > best_len) begin
                            best_len   <= run_next;
                            best_start <= (run_len == 6'd0) ? tap : run_start;
                        end
                    end else begin
                        run_len <= '0;
                    end
                    if (tap == 5'd31) begin
                        state <= S_APPLY;
                    end else begin
                        tap   <= tap + 5'd1;
                        state <= S_LOAD;
                    end
                end
                S_APPLY: begin
                    if (best_len == 6'd0) begin
                        lane_delay_o[lane] <= INIT5;
                        fail_acc           <= 1'b1;
                    end else begin
                        lane_delay_o[lane] <= centre;
                    end
                    eye_width_o[lane] <= best_len;
                    delay_act_o       <= 1'b1;
                    run_len           <= '0;
                    run_start         <= '0;
                    best_len          <= '0;
                    best_start        <= '0;
                    if (lane == LANE_LAST) begin
                        state <= S_DONE;
                    end else begin
                        lane  <= lane + LW'(1);
                        tap   <= '0;
                        state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    fail_o <= fail_acc;
                    state  <= S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule
